// File: rtl/por_licz_seq_if.sv
// Request/result bundle of the por_licz_seq subtraction sequencer.
// The master issues start with operands and consumes done/diff/borrow/flags.
interface por_licz_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         lt;
  logic         eq;
  logic         gt;

  modport master (
    output start, opa, opb, bin,
    input  busy, done, diff, borrow, lt, eq, gt
  );

  modport slave (
    input  start, opa, opb, bin,
    output busy, done, diff, borrow, lt, eq, gt
  );
endinterface

// File: rtl/por_licz_seq.sv
// Multi-nibble subtraction sequencer around an external 4-bit ripple-borrow subtractor.
// Feeds one nibble per cycle, LS first, and registers the difference plus LT/EQ/GT flags.
module por_licz_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  por_licz_seq_if.slave        bus,
  output logic [3:0]           sub_a,
  output logic [3:0]           sub_b,
  output logic                 sub_cin,
  input  logic [3:0]           sub_q,
  input  logic                 sub_cout
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StStep, StFin} state_e;

  state_e         state_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] idx_nxt;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic           last;
  logic           accept;

  assign idx_nxt = idx_q + IdxW'(1);
  assign last    = (idx_q == IdxW'(NIBBLES - 1));
  // The FIN cycle already accepts a new request, giving one op per NIBBLES+1 cycles.
  assign accept  = bus.start && ((state_q == StIdle) || (state_q == StFin));

  always_comb begin
    acc_d = acc_q;
    acc_d[{idx_q, 2'b00} +: 4] = sub_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      sub_a      <= '0;
      sub_b      <= '0;
      sub_cin    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.lt     <= 1'b0;
      bus.eq     <= 1'b0;
      bus.gt     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          if (accept) begin
            opa_q    <= bus.opa;
            opb_q    <= bus.opb;
            idx_q    <= '0;
            acc_q    <= '0;
            sub_a    <= bus.opa[3:0];
            sub_b    <= bus.opb[3:0];
            // sub_cin doubles as the chained borrow register
            sub_cin  <= bus.bin;
            bus.busy <= 1'b1;
            state_q  <= StStep;
          end else begin
            state_q <= StIdle;
          end
        end
        StStep: begin
          acc_q <= acc_d;
          idx_q <= idx_nxt;
          if (last) begin
            sub_a      <= '0;
            sub_b      <= '0;
            sub_cin    <= 1'b0;
            bus.diff   <= acc_d;
            bus.borrow <= sub_cout;
            bus.lt     <= sub_cout;
            bus.eq     <= !sub_cout && (acc_d == '0);
            bus.gt     <= !sub_cout && (acc_d != '0);
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state_q    <= StFin;
          end else begin
            sub_a   <= opa_q[{idx_nxt, 2'b00} +: 4];
            sub_b   <= opb_q[{idx_nxt, 2'b00} +: 4];
            sub_cin <= sub_cout;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_por_licz_seq.sv
// Self-checking bench for por_licz_seq: NIBBLES=4 directed cases and a NIBBLES=2 sweep,
// each DUT closed around a behavioural 4-bit ripple-borrow subtractor.
module tb_por_licz_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  por_licz_seq_if #(.NIBBLES(4)) b4 ();
  por_licz_seq_if #(.NIBBLES(2)) b2 ();

  logic [3:0] s4_a, s4_b, s4_q, s2_a, s2_b, s2_q;
  logic       s4_cin, s4_cout, s2_cin, s2_cout;

  // sub4b: Q = A - B - C_wej, C_wyj = borrow out of the MSB slice
  assign {s4_cout, s4_q} = {1'b0, s4_a} - {1'b0, s4_b} - {4'b0000, s4_cin};
  assign {s2_cout, s2_q} = {1'b0, s2_a} - {1'b0, s2_b} - {4'b0000, s2_cin};

  por_licz_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave),
    .sub_a(s4_a), .sub_b(s4_b), .sub_cin(s4_cin), .sub_q(s4_q), .sub_cout(s4_cout)
  );

  por_licz_seq #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave),
    .sub_a(s2_a), .sub_b(s2_b), .sub_cin(s2_cin), .sub_q(s2_q), .sub_cout(s2_cout)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp4_q[$];
  logic [11:0] exp2_q[$];

  function automatic logic [11:0] model2(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin);
    logic [8:0] f;
    f = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    return {f[7:0], f[8], f[8], !f[8] && (f[7:0] == 8'd0), !f[8] && (f[7:0] != 8'd0)};
  endfunction

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [19:0] exp);
    b4.opa = a; b4.opb = b; b4.bin = bin; b4.start = 1'b1;
    exp4_q.push_back(exp);
    @(negedge clk);
    b4.start = 1'b0;
  endtask

  task automatic collect4(input string name, input int lat);
    int n = 0;
    logic [19:0] got, exp;
    while (b4.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = (exp4_q.size() > 0) ? exp4_q.pop_front() : 20'h0;
    checks++;
    if (b4.done !== 1'b1) begin
      errors++;
      $display("FAIL %s: no DONE within 20 cycles", name);
    end else begin
      got = {b4.diff, b4.borrow, b4.lt, b4.eq, b4.gt};
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got diff/b/lt/eq/gt %h, want %h", name, got, exp);
      end
      checks++;
      if (n !== lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d, want %0d", name, n, lat);
      end
    end
  endtask

  task automatic start2(input logic [7:0] a, input logic [7:0] b, input logic bin);
    b2.opa = a; b2.opb = b; b2.bin = bin; b2.start = 1'b1;
    exp2_q.push_back(model2(a, b, bin));
    @(negedge clk);
    b2.start = 1'b0;
  endtask

  task automatic collect2(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n = 0;
    logic [11:0] got, exp;
    while (b2.done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    exp = (exp2_q.size() > 0) ? exp2_q.pop_front() : 12'h0;
    got = {b2.diff, b2.borrow, b2.lt, b2.eq, b2.gt};
    checks++;
    if (b2.done !== 1'b1 || n !== 2 || got !== exp) begin
      errors++;
      $display("FAIL sweep2 %h-%h-%b: done %b lat %0d got %h, want %h", a, b, bin, b2.done,
               n, got, exp);
    end
  endtask

  task automatic no_done4(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (b4.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s: got %0d DONE pulses, want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    logic [28:0] got4;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got4 = {s4_a, s4_b, s4_cin, b4.busy, b4.done, b4.diff, b4.borrow, b4.lt, b4.eq, b4.gt};
    checks++;
    if (got4 !== 29'h0) begin
      errors++;
      $display("FAIL reset4: got %h, want 0", got4);
    end
    checks++;
    if ({s2_a, s2_b, s2_cin, b2.busy, b2.done, b2.diff} !== 18'h0) begin
      errors++;
      $display("FAIL reset2: got %h, want 0", {s2_a, s2_b, s2_cin, b2.busy, b2.done, b2.diff});
    end
  endtask

  task automatic test_basic();
    start4(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0, 1'b1});
    checks++;
    if (b4.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, want 1", b4.busy);
    end
    collect4("sub_1234", 4);
    @(negedge clk);
    checks++;
    if ({b4.done, b4.busy, b4.diff} !== {2'b00, 16'h1000}) begin
      errors++;
      $display("FAIL hold_after_done: got %h, want %h", {b4.done, b4.busy, b4.diff},
               {2'b00, 16'h1000});
    end
  endtask

  task automatic test_borrow_ripple();
    start4(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    checks++;
    if ({s4_b, s4_cin} !== {4'h1, 1'b0}) begin
      errors++;
      $display("FAIL slice0_drive: got %h, want %h", {s4_b, s4_cin}, {4'h1, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({s4_b, s4_cin} !== {4'h0, 1'b1}) begin
      errors++;
      $display("FAIL slice1_borrow: got %h, want %h", {s4_b, s4_cin}, {4'h0, 1'b1});
    end
    collect4("ripple", 3);
  endtask

  task automatic test_equal();
    start4(16'hABCD, 16'hABCD, 1'b0, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    collect4("eq_bin0", 4);
    start4(16'hABCD, 16'hABCD, 1'b1, {16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    collect4("eq_bin1", 4);
  endtask

  task automatic test_busy_ignore();
    start4(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0, 1'b1});
    b4.opa = 16'h9999; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    collect4("busy_ignore", 3);
    no_done4("no_queued_op", 8);
  endtask

  task automatic test_back_to_back();
    start4(16'h5555, 16'h1111, 1'b0, {16'h4444, 1'b0, 1'b0, 1'b0, 1'b1});
    collect4("b2b_first", 4);
    start4(16'h1111, 16'h2222, 1'b0, {16'hEEEF, 1'b1, 1'b1, 1'b0, 1'b0});
    checks++;
    if ({b4.busy, b4.diff, b4.gt} !== {1'b1, 16'h4444, 1'b1}) begin
      errors++;
      $display("FAIL b2b_accept_hold: got %h, want %h", {b4.busy, b4.diff, b4.gt},
               {1'b1, 16'h4444, 1'b1});
    end
    collect4("b2b_second", 4);
  endtask

  task automatic test_abort();
    @(negedge clk);
    b4.opa = 16'h8000; b4.opb = 16'h0001; b4.bin = 1'b0; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({b4.busy, b4.done, b4.diff, b4.borrow, b4.lt, b4.eq, b4.gt, s4_a, s4_b} !== 30'h0)
    begin
      errors++;
      $display("FAIL abort_clear: got %h, want 0",
               {b4.busy, b4.done, b4.diff, b4.borrow, b4.lt, b4.eq, b4.gt, s4_a, s4_b});
    end
    no_done4("abort_no_done", 8);
    start4(16'h0010, 16'h0001, 1'b0, {16'h000F, 1'b0, 1'b0, 1'b0, 1'b1});
    collect4("after_abort", 4);
  endtask

  task automatic test_sweep2();
    logic [7:0] a, b;
    logic       bin;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          a = 8'(i * 17);
          b = 8'(j * 16 + ((i + j) % 16));
          bin = k[0];
          start2(a, b, bin);
          collect2(a, b, bin);
        end
      end
    end
    for (int r = 0; r < 300; r++) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      bin = 1'($urandom_range(1));
      start2(a, b, bin);
      collect2(a, b, bin);
    end
  endtask

  initial begin
    b4.start = 1'b0; b4.opa = '0; b4.opb = '0; b4.bin = 1'b0;
    b2.start = 1'b0; b2.opa = '0; b2.opb = '0; b2.bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_equal();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_sweep2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
